// File: rtl/fpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fpu_pkg                                                      |
// | Description : Shared FPU constants: opcodes, flag indices, FSM encoding,   |
// |               and qNaN / infinity bit-pattern builders.                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package fpu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;

    localparam int ERR_INV = 3;
    localparam int ERR_OVF = 2;
    localparam int ERR_UNF = 1;
    localparam int ERR_INX = 0;

    localparam int STATE_W = 3;
    localparam logic [STATE_W-1:0] S_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] S_ALIGN = 3'd1;
    localparam logic [STATE_W-1:0] S_ADD   = 3'd2;
    localparam logic [STATE_W-1:0] S_NORM  = 3'd3;
    localparam logic [STATE_W-1:0] S_ROUND = 3'd4;
    localparam logic [STATE_W-1:0] S_DONE  = 3'd5;

    // Patterns are right-aligned in 64 bits; callers truncate to their width.
    function automatic logic [63:0] qnan_bits(input int exp_w, input int man_w);
        return ((64'd1 << (exp_w + 1)) - 64'd1) << (man_w - 1);
    endfunction

    function automatic logic [63:0] inf_bits(input logic sign, input int exp_w, input int man_w);
        return ({63'd0, sign} << (exp_w + man_w)) | (((64'd1 << exp_w) - 64'd1) << man_w);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fpu_lzc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fpu_lzc                                                      |
// | Description : Combinational leading-zero counter; all-zero input gives     |
// |               WIDTH.                                                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fpu_lzc #(
    parameter  int WIDTH = 27,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] i_data,
    output logic [CNT_W-1:0] o_count
);

    // Scan upward so the highest set bit has the final say.
    always_comb begin
        o_count = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (i_data[i]) begin
                o_count = CNT_W'(WIDTH - 1 - i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp_addsub_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fp_addsub_seq                                                |
// | Description : Multi-cycle IEEE-754-style add/subtract, parametrised        |
// |               precision, valid/ready on both sides.                        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fp_addsub_seq
    import fpu_pkg::*;
#(
    parameter  int EXP_W = 8,
    parameter  int MAN_W = 23,
    localparam int W     = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   operation,
    input  logic [W-1:0] opa,
    input  logic [W-1:0] opb,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out,
    output logic [3:0]   errors
);

    localparam int SIG_W = MAN_W + 1;
    localparam int FLD_W = MAN_W + 4;
    localparam int SUM_W = MAN_W + 5;
    localparam int MR_W  = MAN_W + 1;
    localparam int EW    = EXP_W + 2;
    localparam int LZC_W = $clog2(FLD_W + 1);
    localparam logic [W-1:0]     c_QNAN    = W'(qnan_bits(EXP_W, MAN_W));
    localparam logic [EW-1:0]    c_EXP_MAX = EW'((1 << EXP_W) - 1);
    localparam logic [EXP_W-1:0] c_SH_MAX  = EXP_W'(MAN_W + 3);

    logic [STATE_W-1:0] r_state;
    logic [1:0]         r_op;
    logic [W-1:0]       r_opa, r_opb;
    logic               r_sign, r_zero_sign, r_eff_sub, r_spec;
    logic [W-1:0]       r_spec_val;
    logic [3:0]         r_spec_err;
    logic [EW-1:0]      r_exp, r_nexp;
    logic [FLD_W-1:0]   r_siga, r_sigb, r_norm;
    logic [SUM_W-1:0]   r_sum;

    logic               w_sa, w_sb, w_swap, w_xs, w_lost;
    logic [EXP_W-1:0]   w_ea, w_eb, w_xe, w_ye, w_d, w_sh;
    logic [MAN_W-1:0]   w_ma, w_mb, w_xm, w_ym;
    logic [W-2:0]       w_maga, w_magb;
    logic [SIG_W-1:0]   w_sigx, w_sigy;
    logic [FLD_W-1:0]   w_bext, w_bsh;
    logic               w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_snan, w_b_snan;
    logic               w_spec;
    logic [W-1:0]       w_spec_val;
    logic [3:0]         w_spec_err;
    logic [LZC_W-1:0]   w_lzc;
    logic               w_zero, w_inx, w_rup;
    logic [MR_W-1:0]    w_rman;
    logic [EW-1:0]      w_rexp;
    logic [W-1:0]       w_res;
    logic [3:0]         w_err;

    assign in_ready = (r_state == S_IDLE) && !rst;

    // ALIGN: unpack, order by magnitude, shift the smaller operand with sticky.
    assign w_sa     = r_opa[W-1];
    assign w_sb     = r_opb[W-1] ^ (r_op == OP_SUB);
    assign w_ea     = r_opa[W-2:MAN_W];
    assign w_eb     = r_opb[W-2:MAN_W];
    assign w_ma     = r_opa[MAN_W-1:0];
    assign w_mb     = r_opb[MAN_W-1:0];
    assign w_maga   = (w_ea == '0) ? '0 : {w_ea, w_ma};
    assign w_magb   = (w_eb == '0) ? '0 : {w_eb, w_mb};
    assign w_swap   = w_magb > w_maga;
    assign w_xs     = w_swap ? w_sb : w_sa;
    assign w_xe     = w_swap ? w_eb : w_ea;
    assign w_ye     = w_swap ? w_ea : w_eb;
    assign w_xm     = w_swap ? w_mb : w_ma;
    assign w_ym     = w_swap ? w_ma : w_mb;
    assign w_sigx   = (w_xe == '0) ? '0 : {1'b1, w_xm};
    assign w_sigy   = (w_ye == '0) ? '0 : {1'b1, w_ym};
    assign w_d      = w_xe - w_ye;
    assign w_sh     = (w_d > c_SH_MAX) ? c_SH_MAX : w_d;
    assign w_bext   = {w_sigy, 3'b000};
    assign w_bsh    = w_bext >> w_sh;
    assign w_lost   = |(w_bext & ~({FLD_W{1'b1}} << w_sh));

    assign w_a_nan  = (&w_ea) && (|w_ma);
    assign w_b_nan  = (&w_eb) && (|w_mb);
    assign w_a_inf  = (&w_ea) && !(|w_ma);
    assign w_b_inf  = (&w_eb) && !(|w_mb);
    assign w_a_snan = w_a_nan && !w_ma[MAN_W-1];
    assign w_b_snan = w_b_nan && !w_mb[MAN_W-1];

    always_comb begin
        w_spec     = 1'b1;
        w_spec_val = c_QNAN;
        w_spec_err = '0;
        if (r_op[1]) begin
            w_spec_err[ERR_INV] = 1'b1;
        end else if (w_a_nan || w_b_nan) begin
            w_spec_err[ERR_INV] = w_a_snan | w_b_snan;
        end else if (w_a_inf && w_b_inf && (w_sa != w_sb)) begin
            w_spec_err[ERR_INV] = 1'b1;
        end else if (w_a_inf) begin
            w_spec_val = W'(inf_bits(w_sa, EXP_W, MAN_W));
        end else if (w_b_inf) begin
            w_spec_val = W'(inf_bits(w_sb, EXP_W, MAN_W));
        end else begin
            w_spec = 1'b0;
        end
    end

    fpu_lzc #(.WIDTH(FLD_W)) u_lzc (
        .i_data  (r_sum[FLD_W-1:0]),
        .o_count (w_lzc)
    );

    // A clear hidden bit after normalisation can only mean the sum was exactly zero.
    assign w_zero = ~r_norm[FLD_W-1];
    assign w_inx  = |r_norm[2:0];
    assign w_rup  = r_norm[2] & (r_norm[1] | r_norm[0] | r_norm[3]);
    assign w_rman = {1'b0, r_norm[FLD_W-2:3]} + MR_W'(w_rup);
    assign w_rexp = r_nexp + EW'(w_rman[MAN_W]);

    always_comb begin
        w_res          = {r_sign, w_rexp[EXP_W-1:0], w_rman[MAN_W-1:0]};
        w_err          = '0;
        w_err[ERR_INX] = w_inx;
        if (r_spec) begin
            w_res = r_spec_val;
            w_err = r_spec_err;
        end else if (w_zero) begin
            w_res = {r_zero_sign, {(W-1){1'b0}}};
            w_err = '0;
        end else if (r_nexp[EW-1] || (r_nexp == '0)) begin
            w_res          = {r_sign, {(W-1){1'b0}}};
            w_err[ERR_UNF] = 1'b1;
            w_err[ERR_INX] = 1'b1;
        end else if (!w_rexp[EW-1] && (w_rexp >= c_EXP_MAX)) begin
            w_res          = W'(inf_bits(r_sign, EXP_W, MAN_W));
            w_err[ERR_OVF] = 1'b1;
            w_err[ERR_INX] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    r_op  <= operation;
                    r_opa <= opa;
                    r_opb <= opb;
                end
            end
            S_ALIGN: begin
                r_sign      <= w_xs;
                r_zero_sign <= w_sa & w_sb;
                r_eff_sub   <= w_sa ^ w_sb;
                r_exp       <= {2'b00, w_xe};
                r_siga      <= {w_sigx, 3'b000};
                r_sigb      <= {w_bsh[FLD_W-1:1], w_bsh[0] | w_lost};
                r_spec      <= w_spec;
                r_spec_val  <= w_spec_val;
                r_spec_err  <= w_spec_err;
            end
            S_ADD: begin
                r_sum <= r_eff_sub ? ({1'b0, r_siga} - {1'b0, r_sigb})
                                   : ({1'b0, r_siga} + {1'b0, r_sigb});
            end
            S_NORM: begin
                if (r_sum[SUM_W-1]) begin
                    r_norm <= {r_sum[SUM_W-1:2], r_sum[1] | r_sum[0]};
                    r_nexp <= r_exp + EW'(1);
                end else begin
                    r_norm <= r_sum[FLD_W-1:0] << w_lzc;
                    r_nexp <= r_exp - EW'(w_lzc);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            out_valid <= 1'b0;
            out       <= '0;
            errors    <= '0;
        end else begin
            case (r_state)
                S_IDLE:  if (in_valid) r_state <= S_ALIGN;
                S_ALIGN: r_state <= S_ADD;
                S_ADD:   r_state <= S_NORM;
                S_NORM:  r_state <= S_ROUND;
                S_ROUND: begin
                    out       <= w_res;
                    errors    <= w_err;
                    out_valid <= 1'b1;
                    r_state   <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_addsub_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fp_addsub_seq                                             |
// | Description : Directed self-checking bench for single and half precision.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_fp_addsub_seq;

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [1:0]  operation = 2'b00;
    logic [31:0] opa = '0;
    logic [31:0] opb = '0;
    logic        out_ready = 1'b0;
    logic        sel_half = 1'b0;

    logic        s_in_ready, s_out_valid, h_in_ready, h_out_valid;
    logic [31:0] s_out;
    logic [15:0] h_out;
    logic [3:0]  s_errors, h_errors;

    logic        w_s_valid, w_h_valid, w_in_ready, w_out_valid;
    logic [31:0] w_out;
    logic [3:0]  w_errors;

    int n_checks = 0;
    int n_fail   = 0;

    assign w_s_valid   = in_valid & ~sel_half;
    assign w_h_valid   = in_valid & sel_half;
    assign w_in_ready  = sel_half ? h_in_ready  : s_in_ready;
    assign w_out_valid = sel_half ? h_out_valid : s_out_valid;
    assign w_out       = sel_half ? {16'h0000, h_out} : s_out;
    assign w_errors    = sel_half ? h_errors : s_errors;

    fp_addsub_seq u_sp (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (w_s_valid),
        .in_ready  (s_in_ready),
        .operation (operation),
        .opa       (opa),
        .opb       (opb),
        .out_valid (s_out_valid),
        .out_ready (out_ready),
        .out       (s_out),
        .errors    (s_errors)
    );

    fp_addsub_seq #(.EXP_W(5), .MAN_W(10)) u_hp (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (w_h_valid),
        .in_ready  (h_in_ready),
        .operation (operation),
        .opa       (opa[15:0]),
        .opb       (opb[15:0]),
        .out_valid (h_out_valid),
        .out_ready (out_ready),
        .out       (h_out),
        .errors    (h_errors)
    );

    always #5 clk = ~clk;

    // Issue one operation with out_ready high; lat counts edges from accept to out_valid.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic [3:0] err, output int lat);
        int k;
        lat = -1;
        res = '0;
        err = '0;
        k   = 0;
        out_ready = 1'b1;
        @(negedge clk);
        while (w_in_ready !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        operation = op;
        opa       = a;
        opb       = b;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        opa       = ~a;
        opb       = ~b;
        operation = 2'b11;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            #1;
            if (w_out_valid === 1'b1) begin
                lat = i;
                res = w_out;
                err = w_errors;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks += 7;
        if (s_in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_sp_in_ready got=%b exp=0", s_in_ready); end
        if (h_in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_hp_in_ready got=%b exp=0", h_in_ready); end
        if (s_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_sp_out_valid got=%b exp=0", s_out_valid); end
        if (s_out !== 32'h0) begin n_fail++; $display("FAIL reset_sp_out got=%h exp=0", s_out); end
        if (s_errors !== 4'h0) begin n_fail++; $display("FAIL reset_sp_errors got=%b exp=0000", s_errors); end
        if (h_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_hp_out_valid got=%b exp=0", h_out_valid); end
        if (h_out !== 16'h0) begin n_fail++; $display("FAIL reset_hp_out got=%h exp=0", h_out); end
        rst = 1'b0;
        #1;
        n_checks += 2;
        if (s_in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_sp_in_ready got=%b exp=1", s_in_ready); end
        if (h_in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_hp_in_ready got=%b exp=1", h_in_ready); end
    endtask

    task automatic test_add_sub();
        vec_t v [11];
        logic [31:0] res;
        logic [3:0]  err;
        int          lat;
        v[0]  = '{2'b00, 32'h3F800000, 32'h3F800000, 32'h40000000, 4'b0000};
        v[1]  = '{2'b01, 32'h3F800001, 32'h3F800000, 32'h34000000, 4'b0000};
        v[2]  = '{2'b00, 32'h3F800000, 32'h33800000, 32'h3F800000, 4'b0001};
        v[3]  = '{2'b00, 32'h3F800001, 32'h33800000, 32'h3F800002, 4'b0001};
        v[4]  = '{2'b01, 32'h40000000, 32'h3F800000, 32'h3F800000, 4'b0000};
        v[5]  = '{2'b00, 32'h3F800000, 32'hC0000000, 32'hBF800000, 4'b0000};
        v[6]  = '{2'b01, 32'h3F800000, 32'h40000000, 32'hBF800000, 4'b0000};
        v[7]  = '{2'b00, 32'hBF800000, 32'h3F800000, 32'h00000000, 4'b0000};
        v[8]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h80000000, 4'b0000};
        v[9]  = '{2'b00, 32'h00000001, 32'h3F800000, 32'h3F800000, 4'b0000};
        v[10] = '{2'b00, 32'h3F800000, 32'h00800000, 32'h3F800000, 4'b0001};
        sel_half = 1'b0;
        for (int i = 0; i < 11; i++) begin
            run_op(v[i].op, v[i].a, v[i].b, res, err, lat);
            n_checks += 3;
            if (lat !== 4) begin n_fail++; $display("FAIL add_sub[%0d] latency got=%0d exp=4", i, lat); end
            if (res !== v[i].res) begin n_fail++; $display("FAIL add_sub[%0d] out got=%h exp=%h", i, res, v[i].res); end
            if (err !== v[i].err) begin n_fail++; $display("FAIL add_sub[%0d] errors got=%b exp=%b", i, err, v[i].err); end
        end
    endtask

    task automatic test_exceptions();
        vec_t v [9];
        logic [31:0] res;
        logic [3:0]  err;
        int          lat;
        v[0] = '{2'b00, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 4'b0101};
        v[1] = '{2'b01, 32'h7F800000, 32'h7F800000, 32'h7FC00000, 4'b1000};
        v[2] = '{2'b00, 32'h7F800000, 32'h3F800000, 32'h7F800000, 4'b0000};
        v[3] = '{2'b01, 32'h3F800000, 32'h7F800000, 32'hFF800000, 4'b0000};
        v[4] = '{2'b00, 32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'b1000};
        v[5] = '{2'b00, 32'h7FC00000, 32'h3F800000, 32'h7FC00000, 4'b0000};
        v[6] = '{2'b10, 32'h3F800000, 32'h3F800000, 32'h7FC00000, 4'b1000};
        v[7] = '{2'b01, 32'h00800000, 32'h00C00000, 32'h80000000, 4'b0011};
        v[8] = '{2'b00, 32'h7F800000, 32'h7F800000, 32'h7F800000, 4'b0000};
        sel_half = 1'b0;
        for (int i = 0; i < 9; i++) begin
            run_op(v[i].op, v[i].a, v[i].b, res, err, lat);
            n_checks += 3;
            if (lat !== 4) begin n_fail++; $display("FAIL except[%0d] latency got=%0d exp=4", i, lat); end
            if (res !== v[i].res) begin n_fail++; $display("FAIL except[%0d] out got=%h exp=%h", i, res, v[i].res); end
            if (err !== v[i].err) begin n_fail++; $display("FAIL except[%0d] errors got=%b exp=%b", i, err, v[i].err); end
        end
    endtask

    task automatic test_backpressure();
        int k;
        int lat;
        sel_half  = 1'b0;
        out_ready = 1'b1;
        k = 0;
        @(negedge clk);
        while (w_in_ready !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        out_ready = 1'b0;
        operation = 2'b00;
        opa = 32'h3F800000;
        opb = 32'h3F800000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = -1;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            #1;
            if (s_out_valid === 1'b1) begin lat = i; break; end
        end
        n_checks++;
        if (lat !== 4) begin n_fail++; $display("FAIL bp_latency got=%0d exp=4", lat); end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_checks += 4;
            if (s_out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid cyc=%0d got=%b exp=1", c, s_out_valid); end
            if (s_out !== 32'h40000000) begin n_fail++; $display("FAIL bp_hold_out cyc=%0d got=%h exp=40000000", c, s_out); end
            if (s_errors !== 4'b0000) begin n_fail++; $display("FAIL bp_hold_errors cyc=%0d got=%b exp=0000", c, s_errors); end
            if (s_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold_in_ready cyc=%0d got=%b exp=0", c, s_in_ready); end
        end
        out_ready = 1'b1;
        opa = 32'h40000000;
        opb = 32'h40000000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        n_checks += 2;
        if (s_out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid got=%b exp=0", s_out_valid); end
        if (s_in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_no_accept_in_done got=%b exp=1", s_in_ready); end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n_checks++;
        if (s_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_accept_next got=%b exp=0", s_in_ready); end
        lat = -1;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            #1;
            if (s_out_valid === 1'b1) begin lat = i; break; end
        end
        n_checks += 2;
        if (lat !== 4) begin n_fail++; $display("FAIL bp_second_latency got=%0d exp=4", lat); end
        if (s_out !== 32'h40800000) begin n_fail++; $display("FAIL bp_second_out got=%h exp=40800000", s_out); end
    endtask

    task automatic test_reset_abort(input logic half, input logic [31:0] a);
        int k;
        int seen;
        sel_half  = half;
        out_ready = 1'b1;
        k = 0;
        @(negedge clk);
        while (w_in_ready !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        operation = 2'b00;
        opa = a;
        opb = a;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks += 2;
        if (w_out_valid !== 1'b0) begin n_fail++; $display("FAIL abort_valid half=%0b got=%b exp=0", half, w_out_valid); end
        if (w_in_ready !== 1'b0) begin n_fail++; $display("FAIL abort_in_ready half=%0b got=%b exp=0", half, w_in_ready); end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (w_out_valid !== 1'b0) seen++;
        end
        n_checks += 2;
        if (seen !== 0) begin n_fail++; $display("FAIL abort_no_result half=%0b got=%0d cycles valid exp=0", half, seen); end
        if (w_in_ready !== 1'b1) begin n_fail++; $display("FAIL abort_idle half=%0b got=%b exp=1", half, w_in_ready); end
    endtask

    task automatic test_half();
        logic [31:0] res;
        logic [3:0]  err;
        int          lat;
        test_reset_abort(1'b1, 32'h00003C00);
        sel_half = 1'b1;
        run_op(2'b00, 32'h00003C00, 32'h00003C00, res, err, lat);
        n_checks += 3;
        if (lat !== 4) begin n_fail++; $display("FAIL half_latency got=%0d exp=4", lat); end
        if (res !== 32'h00004000) begin n_fail++; $display("FAIL half_out got=%h exp=00004000", res); end
        if (err !== 4'b0000) begin n_fail++; $display("FAIL half_errors got=%b exp=0000", err); end
        sel_half = 1'b0;
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_exceptions();
        test_backpressure();
        test_reset_abort(1'b0, 32'h3F800000);
        test_half();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
